// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field position, HALT encoding and fetch FSM states.
package cpu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam logic [7:0] OPC_HALT = 8'h60;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [7:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding one fetched {instr, pc} pair for decode.
module fetch_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Handshake: a word transfers on a cycle where valid && ready; while valid && !ready
  // the held instr/pc must not change. flush wins over load, load wins over drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem combinationally, registers into a
// valid/ready stage and freezes on HALT until redirected. FETCH_PERF_EN adds perf counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int         MEM_DEPTH   = 256,
  parameter int         PC_W        = $clog2(MEM_DEPTH),
  parameter int         RESET_PC    = 0,
  parameter logic [7:0] HALT_OPCODE = OPC_HALT
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_instr,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_instr,
  output logic [31:0]  out_pc,
  output logic         halted,
  output fetch_state_t fsm_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc;
  logic            fetch;
  logic            halt_hit;

  assign imem_addr = 32'(pc);
  assign fetch     = (state == FS_RUN) && (!out_valid || out_ready) && !redirect_valid;
  assign halt_hit  = (opcode_of(imem_instr) == HALT_OPCODE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect_valid)           state_next = FS_RUN;
    else if (fetch && halt_hit)   state_next = FS_HALTED;
  end

  always_comb begin
    halted = (state == FS_HALTED);
  end

  // The HALT word's address is kept so a later replay/inspection sees where fetch stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  pc <= RESET_PC_W;
    else if (redirect_valid)     pc <= redirect_pc[PC_W-1:0];
    else if (fetch && !halt_hit) pc <= pc + PC_W'(1);
  end

  fetch_out_reg u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (fetch),
    .flush    (redirect_valid),
    .ready    (out_ready),
    .in_instr (imem_instr),
    .in_pc    (32'(pc)),
    .valid    (out_valid),
    .instr    (out_instr),
    .pc       (out_pc)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch && perf_fetch_cnt != 32'hFFFF_FFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (out_valid && !out_ready && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
